// File: rtl/rr_stream_arbiter_if.sv
// Valid/ready bundle between NUM_REQ producers, the round-robin
// arbiter and the shared downstream write port.
interface rr_stream_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA    = 8,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      iValid;
    logic [NUM_REQ-1:0]      iReady;
    logic [NUM_REQ*DATA-1:0] iDat;
    logic [NUM_REQ-1:0]      iLast;
    logic                    oValid;
    logic                    oReady;
    logic [DATA-1:0]         oDat;
    logic [SRC_W-1:0]        oSrc;
    logic                    oLast;

    modport master (
        input  iValid, iDat, iLast, oReady,
        output iReady, oValid, oDat, oSrc, oLast
    );

    modport slave (
        output iValid, iDat, iLast, oReady,
        input  iReady, oValid, oDat, oSrc, oLast
    );
endinterface

// File: rtl/rr_stream_arbiter.sv
// Round-robin N:1 stream arbiter with a registered, source-tagged output.
// Define ARB_LOCK_EN to hold the grant on one requester until its iLast beat.
module rr_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA    = 8,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                clear,
    rr_stream_arbiter_if.master bus,
    output logic                busy
);
    logic [SRC_W-1:0]   ptr;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [SRC_W-1:0]   win;
    logic [DATA-1:0]    selDat;
    logic               selLast;
    logic               load;
    logic               accept;
    int                 idx;

`ifdef ARB_LOCK_EN
    logic             lock;
    logic [SRC_W-1:0] lockSrc;
`endif

    function automatic logic [SRC_W-1:0] wrapNext(input logic [SRC_W-1:0] w);
        return (w == SRC_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;
    endfunction

    always_comb begin
        elig = bus.iValid;
`ifdef ARB_LOCK_EN
        if (lock) elig = bus.iValid & (NUM_REQ'(1) << lockSrc);
`endif
        found   = 1'b0;
        win     = '0;
        selDat  = '0;
        selLast = 1'b0;
        idx     = 0;
        // Scan from ptr upward, wrapping; first eligible requester wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                win     = SRC_W'(idx);
                selDat  = bus.iDat[idx*DATA +: DATA];
                selLast = bus.iLast[idx];
            end
        end
    end

    assign load   = !bus.oValid || bus.oReady;
    assign accept = found && load && rstN && !clear;

    always_comb begin
        bus.iReady = '0;
        if (accept) bus.iReady[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstN || clear) begin
            bus.oValid <= 1'b0;
            bus.oDat   <= '0;
            bus.oSrc   <= '0;
            bus.oLast  <= 1'b0;
            ptr        <= '0;
`ifdef ARB_LOCK_EN
            lock       <= 1'b0;
            lockSrc    <= '0;
`endif
        end else if (accept) begin
            bus.oValid <= 1'b1;
            bus.oDat   <= selDat;
            bus.oSrc   <= win;
            bus.oLast  <= selLast;
`ifdef ARB_LOCK_EN
            // A mid-packet beat pins the grant; ptr moves only at packet end.
            if (!selLast) begin
                lock    <= 1'b1;
                lockSrc <= win;
            end else begin
                lock    <= 1'b0;
                ptr     <= wrapNext(win);
            end
`else
            ptr        <= wrapNext(win);
`endif
        end else if (bus.oValid && bus.oReady) begin
            bus.oValid <= 1'b0;
        end
    end

`ifdef ARB_LOCK_EN
    assign busy = bus.oValid || lock;
`else
    assign busy = bus.oValid;
`endif
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed plus random checks of rr_stream_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_rr_stream_arbiter;
    localparam int N = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rstN;
    logic clear;
    logic busy;

    rr_stream_arbiter_if #(.NUM_REQ(N), .DATA(D)) bus ();

    rr_stream_arbiter #(.NUM_REQ(N), .DATA(D)) dut (
        .clk  (clk),
        .rstN (rstN),
        .clear(clear),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int mPtr     = 0;
    bit mLock    = 1'b0;
    int mLockSrc = 0;
    bit mOValid  = 1'b0;
    int mODat    = 0;
    int mOSrc    = 0;
    bit mOLast   = 1'b0;

    int lockSeq[5] = '{1, 1, 1, 2, 3};
    int freeSeq[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input string tag);
        int w;
        bit load;
        bit flush;
        int dat;
        bit last;
        logic [N-1:0] expReady;
        #1;
        load  = !mOValid || bus.oReady;
        flush = !rstN || clear;
        w     = -1;
        dat   = 0;
        last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (mPtr + i) % N;
            if (w < 0 && bus.iValid[k] && (!mLock || k == mLockSrc)) w = k;
        end
        if (w >= 0) begin
            dat  = int'(bus.iDat[w*D +: D]);
            last = bus.iLast[w];
        end
        expReady = '0;
        if (!flush && load && w >= 0) expReady[w] = 1'b1;
        chk({tag, ".iReady"}, 32'(bus.iReady), 32'(expReady));
        @(posedge clk);
        if (flush) begin
            mOValid = 0; mODat = 0; mOSrc = 0; mOLast = 0;
            mPtr = 0; mLock = 0; mLockSrc = 0;
        end else if (load && w >= 0) begin
            mOValid = 1; mODat = dat; mOSrc = w; mOLast = last;
`ifdef ARB_LOCK_EN
            if (!last) begin
                mLock = 1; mLockSrc = w;
            end else begin
                mLock = 0; mPtr = (w + 1) % N;
            end
`else
            mPtr = (w + 1) % N;
`endif
        end else if (mOValid && bus.oReady) begin
            mOValid = 0;
        end
        #1;
        chk({tag, ".oValid"}, 32'(bus.oValid), 32'(mOValid));
        chk({tag, ".oDat"}, 32'(bus.oDat), mODat);
        chk({tag, ".oSrc"}, 32'(bus.oSrc), mOSrc);
        chk({tag, ".oLast"}, 32'(bus.oLast), 32'(mOLast));
        chk({tag, ".busy"}, 32'(busy), 32'(mOValid || mLock));
    endtask

    initial begin
        rstN       = 1'b0;
        clear      = 1'b0;
        bus.iValid = '1;
        bus.iLast  = '1;
        bus.oReady = 1'b1;
        for (int k = 0; k < N; k++) bus.iDat[k*D +: D] = D'(8'h10 + k);

        // Reset with every requester valid, then idle
        cycle("rst0");
        cycle("rst1");
        rstN       = 1'b1;
        bus.iValid = '0;
        cycle("idle");
        chk("idle.oValid", 32'(bus.oValid), 0);
        chk("idle.oSrc", 32'(bus.oSrc), 0);
        chk("idle.busy", 32'(busy), 0);

        // Round robin, all valid
        bus.iValid = '1;
        for (int j = 0; j < 5; j++) begin
            cycle("rr");
            chk("rr.src", 32'(bus.oSrc), j % 4);
            chk("rr.dat", 32'(bus.oDat), 32'h10 + j % 4);
        end
        cycle("rr5");
        chk("rr5.src", 32'(bus.oSrc), 1);

        // Skip and wrap from ptr=2
        bus.iValid = 4'b1010;
        cycle("skip0"); chk("skip0.src", 32'(bus.oSrc), 3);
        cycle("skip1"); chk("skip1.src", 32'(bus.oSrc), 1);
        cycle("skip2"); chk("skip2.src", 32'(bus.oSrc), 3);

        // Backpressure with 8'h12 held in the output register
        bus.iValid = 4'b0100;
        cycle("bp0");
        chk("bp0.dat", 32'(bus.oDat), 32'h12);
        bus.oReady = 1'b0;
        bus.iValid = '1;
        repeat (3) begin
            cycle("bp");
            chk("bp.dat", 32'(bus.oDat), 32'h12);
            chk("bp.src", 32'(bus.oSrc), 2);
            chk("bp.rdy", 32'(bus.iReady), 0);
        end
        bus.oReady = 1'b1;
        cycle("bpPop");
        chk("bpPop.src", 32'(bus.oSrc), 3);
        chk("bpPop.valid", 32'(bus.oValid), 1);

        // Clear colliding with a would-be accept
        bus.iValid = 4'h4;
        clear      = 1'b1;
        cycle("clr");
        chk("clr.valid", 32'(bus.oValid), 0);
        clear = 1'b0;
        cycle("clrPost");
        chk("clrPost.src", 32'(bus.oSrc), 2);

        // Packet from requester 1: A,B,C with iLast 0,0,1
        clear = 1'b1;
        cycle("pkClr");
        clear      = 1'b0;
        bus.iValid = 4'b0001;
        bus.iLast  = '1;
        cycle("pkPre");
        bus.iValid = '1;
        bus.iLast  = 4'b1101;
        for (int j = 0; j < 5; j++) begin
            if (j == 2) bus.iLast = '1;
            cycle("pk");
`ifdef ARB_LOCK_EN
            chk("pk.src", 32'(bus.oSrc), lockSeq[j]);
`else
            chk("pk.src", 32'(bus.oSrc), freeSeq[j]);
`endif
        end

        // Random traffic against the model
        bus.iLast = '1;
        repeat (400) begin
            bus.iValid = N'($urandom);
            bus.iLast  = N'($urandom);
            bus.iDat   = (N*D)'($urandom);
            bus.oReady = ($urandom_range(3) != 0);
            clear      = ($urandom_range(31) == 0);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
